// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with a small bus register interface.
// Runs the host-request sequence on the open-drain clock/data lines and reports status.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ps2_clock,
    input  logic        ps2_data,
    output logic        ps2_clock_oe,
    output logic        ps2_data_oe,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o
);

    typedef enum logic [1:0] {B_IDLE, B_BUSY, B_DONE} bus_state_t;
    typedef enum logic [2:0] {T_IDLE, T_INHIBIT, T_START, T_SHIFT, T_ACK, T_WAITIDLE} tx_state_t;

    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    bus_state_t  bus_q, bus_d;
    tx_state_t   tx_q, tx_d;
    logic [2:0]  clk_sr_q, data_sr_q;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;
    logic        par_q, par_d;
    logic        clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic        done_q, done_d, err_q, err_d, to_q, to_d, ovr_q, ovr_d;
    logic [31:0] dat_o_q, dat_o_d;
    logic        ack_q, ack_d;
    logic        fall_s, busy_s, wr0_s, wr1_s, start_s, clr_s;
    logic        done_set_s, err_set_s, to_set_s;
    logic [9:0]  frame_s;
    logic [31:0] status_s;
    logic        unused_s;

    assign unused_s     = ^{sel_i, dat_i[31:8]};
    assign fall_s       = (clk_sr_q[2:1] == 2'b10);
    assign busy_s       = (tx_q != T_IDLE);
    assign frame_s      = {1'b1, par_q, byte_q};
    assign status_s     = {27'h0, ovr_q, to_q, err_q, done_q, busy_s};
    assign start_s      = wr0_s & ~busy_s;
    assign clr_s        = wr1_s & dat_i[0];
    assign ps2_clock_oe = clk_oe_q;
    assign ps2_data_oe  = dat_oe_q;
    assign dat_o        = dat_o_q;
    assign ack_o        = ack_q;

    // Bus handshake: strobe sampled, access performed, then a one-cycle ack.
    always_comb begin
        bus_d   = bus_q;
        dat_o_d = dat_o_q;
        wr0_s   = 1'b0;
        wr1_s   = 1'b0;
        case (bus_q)
            B_IDLE: begin
                if (cyc_i && stb_i) bus_d = B_BUSY;
                else                bus_d = B_IDLE;
            end
            B_BUSY: begin
                bus_d = B_DONE;
                if (we_i) begin
                    wr0_s = ~adr_i;
                    wr1_s = adr_i;
                end else begin
                    dat_o_d = adr_i ? {24'h0, byte_q} : status_s;
                end
            end
            B_DONE:  bus_d = B_IDLE;
            default: bus_d = B_IDLE;
        endcase
        ack_d = (bus_d == B_DONE);
    end

    // Transmit sequencer; line enables are computed one cycle ahead and registered.
    always_comb begin
        tx_d       = tx_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        clk_oe_d   = 1'b0;
        dat_oe_d   = dat_oe_q;
        done_set_s = 1'b0;
        err_set_s  = 1'b0;
        to_set_s   = 1'b0;
        case (tx_q)
            T_IDLE: begin
                dat_oe_d = 1'b0;
                if (start_s) begin
                    tx_d     = T_INHIBIT;
                    cnt_d    = 20'd0;
                    clk_oe_d = 1'b1;
                end else begin
                    tx_d = T_IDLE;
                end
            end
            T_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    tx_d     = T_START;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            T_START: begin
                idx_d = 4'd0;
                cnt_d = 20'd0;
                tx_d  = T_SHIFT;
            end
            T_SHIFT: begin
                if (fall_s) begin
                    cnt_d    = 20'd0;
                    dat_oe_d = ~frame_s[idx_q];
                    if (idx_q == 4'd9) tx_d = T_ACK;
                    else               idx_d = idx_q + 4'd1;
                end else if (cnt_q == TO_LAST) begin
                    to_set_s = 1'b1;
                    dat_oe_d = 1'b0;
                    tx_d     = T_IDLE;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            T_ACK: begin
                if (fall_s) begin
                    cnt_d      = 20'd0;
                    done_set_s = 1'b1;
                    err_set_s  = data_sr_q[1];
                    tx_d       = T_WAITIDLE;
                end else if (cnt_q == TO_LAST) begin
                    to_set_s = 1'b1;
                    dat_oe_d = 1'b0;
                    tx_d     = T_IDLE;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            T_WAITIDLE: begin
                if (clk_sr_q[1] && data_sr_q[1]) begin
                    tx_d = T_IDLE;
                end else if (fall_s) begin
                    cnt_d = 20'd0;
                end else if (cnt_q == TO_LAST) begin
                    to_set_s = 1'b1;
                    dat_oe_d = 1'b0;
                    tx_d     = T_IDLE;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            default: begin
                tx_d     = T_IDLE;
                dat_oe_d = 1'b0;
            end
        endcase
    end

    // Sticky status flags and the transmit byte latch; a set beats a same-cycle clear.
    always_comb begin
        if (done_set_s)              done_d = 1'b1;
        else if (clr_s || start_s)   done_d = 1'b0;
        else                         done_d = done_q;
        if (err_set_s)               err_d = 1'b1;
        else if (clr_s || start_s)   err_d = 1'b0;
        else                         err_d = err_q;
        if (to_set_s)                to_d = 1'b1;
        else if (clr_s || start_s)   to_d = 1'b0;
        else                         to_d = to_q;
        if (wr0_s && busy_s)         ovr_d = 1'b1;
        else if (clr_s)              ovr_d = 1'b0;
        else                         ovr_d = ovr_q;
        if (start_s) begin
            byte_d = dat_i[7:0];
            par_d  = odd_parity(dat_i[7:0]);
        end else begin
            byte_d = byte_q;
            par_d  = par_q;
        end
    end

    // State registers; lines are sampled into idle-high synchronizers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_q     <= B_IDLE;
            tx_q      <= T_IDLE;
            clk_sr_q  <= 3'b111;
            data_sr_q <= 3'b111;
            cnt_q     <= 20'd0;
            idx_q     <= 4'd0;
            byte_q    <= 8'h00;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            ovr_q     <= 1'b0;
            dat_o_q   <= 32'h0;
            ack_q     <= 1'b0;
        end else begin
            bus_q     <= bus_d;
            tx_q      <= tx_d;
            clk_sr_q  <= {clk_sr_q[1:0], ps2_clock};
            data_sr_q <= {data_sr_q[1:0], ps2_data};
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            to_q      <= to_d;
            ovr_q     <= ovr_d;
            dat_o_q   <= dat_o_d;
            ack_q     <= ack_d;
        end
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter on the Wishbone-style I/O bus, the counterpart of the keyboard receive path. It sends command bytes to the keyboard, such as LED set (0xED), reset (0xFF) and typematic rate (0xF3), using the PS/2 host-request sequence. It drives the shared open-drain clock and data lines through active-high pull-low enables and reports completion, device acknowledge and timeout in a status register.

## Interface
- INHIBIT_CYCLES, default 5000: clock pull-low time, 100 µs at 50 MHz. Must be < 2^20.
- TIMEOUT_CYCLES, default 750000: maximum clk_i cycles between device clock falling edges in any wait state, 15 ms at 50 MHz. Must be < 2^20.
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- ps2_clock  in  1  PS/2 clock line level, asynchronous
- ps2_data  in  1  PS/2 data line level, asynchronous
- ps2_clock_oe  out  1  1 = pull clock low
- ps2_data_oe  out  1  1 = pull data low
- cyc_i, stb_i, we_i  in  1 each  bus cycle, strobe, write
- sel_i  in  4  byte selects (ignored)
- adr_i  in  1  register select
- dat_i  in  32  write data
- dat_o  out  32  read data (registered)
- ack_o  out  1  bus acknowledge

## Operation
- Input synchronization:
  - 3-bit shift registers on ps2_clock and ps2_data.
  - Falling edge = clk_sr[2:1]==2'b10.
  - Data sample = data_sr[1].
- Register map:
  - adr 0 write: if not busy, latch dat_i[7:0], compute odd parity (~^byte), clear done/ack_err/timeout, start a transfer. If busy, ignore the byte and set sticky overrun.
  - adr 0 read: dat_o = {27'h0, overrun, timeout, ack_err, done, busy}.
  - adr 1 write: dat_i[0]=1 clears overrun, done, ack_err and timeout.
  - adr 1 read: dat_o = {24'h0, last transmitted byte}.
- Bus FSM states: B_IDLE, B_BUSY, B_DONE.
  - B_IDLE → B_BUSY on cyc_i&stb_i.
  - B_BUSY performs the access and loads dat_o → B_DONE.
  - B_DONE asserts ack_o, then returns to B_IDLE.
- Transmit FSM:
  - T_IDLE: both oe = 0, busy = 0. A start request → T_INHIBIT, counter = 0.
  - T_INHIBIT: clock_oe = 1. When counter == INHIBIT_CYCLES-1, set data_oe = 1 (start bit) → T_START.
  - T_START: clock_oe = 1 and data_oe = 1 for exactly one cycle. Then release the clock (clock_oe = 0), bit index = 0 → T_SHIFT.
  - T_SHIFT: on each falling edge, drive bit index 0–7 = byte LSB-first, 8 = parity, 9 = stop (data_oe = 0). Drive rule: data_oe = ~bit. After the stop bit is driven → T_ACK.
  - T_ACK: on the next falling edge, sample data. Data 0 sets done; data 1 sets done and ack_err. → T_WAITIDLE.
  - T_WAITIDLE: wait until the synchronized clock and data are both 1 → T_IDLE.
- Timeout:
  - In T_SHIFT, T_ACK and T_WAITIDLE, the cycle counter resets on every falling edge.
  - Reaching TIMEOUT_CYCLES sets timeout, forces both oe = 0 and → T_IDLE. done stays 0.
- busy = (tx state != T_IDLE).

## Timing
- Reset values: ps2_clock_oe = 0, ps2_data_oe = 0, ack_o = 0, dat_o = 0, all flags 0, FSMs idle.
- Reset mid-transfer releases both lines immediately.
- ack_o is high for exactly 1 cycle. It occurs 2 cycles after the first cycle with cyc_i&stb_i sampled high.
- A write to adr 0 is accepted in B_BUSY. clock_oe rises on the following cycle.
- Inhibit: clock_oe is low-driving for INHIBIT_CYCLES+1 cycles.
- Data bit timing: each bit changes within 1 cycle after the synchronized falling edge is detected. Total delay from ps2_clock falling = 3 clk_i cycles.
- A falling edge and a timeout in the same cycle: the edge wins and the counter resets.
- A flag-clear write in the same cycle as a flag set: the set wins.
- Falling edges in T_IDLE and T_INHIBIT are ignored.

## Test plan
- Send 0xED with a device model (answers ≥1 µs after clock release, ~12 kHz clock, ack low on edge 11):
  - Required: clock held low 5000 cycles, then start bit 0.
  - Bits 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - Status = 0x02 after idle.
- Send 0x01 with a device that does not acknowledge (data stays 1 on edge 11):
  - Required: parity bit 0, status = 0x06 (done + ack_err).
- Device silent after clock release:
  - Required: after 750000 cycles, both oe = 0 and status = 0x08 (timeout), with no further line activity.
- Write 0x55 to adr 0 while busy:
  - Required: byte not sent, overrun set, status bit 4 = 1.
  - Writing 1 to adr 1 clears status to 0x00.
- Assert rst_i during T_SHIFT after bit 3:
  - Required: ps2_clock_oe = ps2_data_oe = 0 in the same cycle, status reads 0.
  - A new 0xFF write then transmits cleanly with parity 1.
- Back-to-back reads of adr 1:
  - Required: each read gets a 1-cycle ack_o exactly 2 cycles after its strobe, and dat_o = last byte.
